// File: rtl/c432_lock_pkg.sv
// rtl/c432_lock_pkg.sv - shared widths, key slicing indices and loader states for the c432 key path
package c432_lock_pkg;

    localparam int MUX_W  = 4;
    localparam int XOR_W  = 22;
    localparam int KEY_W  = MUX_W + XOR_W;
    localparam int CNT_W  = 5;

    // key_o[P_BASE +: MUX_W] drives p1..p4, key_o[X_BASE +: XOR_W] drives X_1..X_22
    localparam int P_BASE = 0;
    localparam int X_BASE = MUX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        PAR   = 2'd2,
        CHECK = 2'd3
    } loader_state_t;

endpackage

// File: rtl/key_shift_par.sv
// rtl/key_shift_par.sv - LSB-first key shift register with saturating bit counter and running parity
module key_shift_par
    import c432_lock_pkg::*;
#(
    parameter int SR_W = KEY_W,
    parameter int CW   = CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            shift_en,
    input  logic            par_en,
    input  logic            bit_in,
    output logic [SR_W-1:0] sr,
    output logic [CW-1:0]   cnt,
    output logic            parity
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            sr     <= '0;
            cnt    <= '0;
            parity <= 1'b0;
        end else begin
            // Shifting right means the first bit ends up in bit 0 after SR_W shifts
            if (shift_en) begin
                sr <= {bit_in, sr[SR_W-1:1]};
                if (cnt != CW'(SR_W))
                    cnt <= cnt + 1'b1;
            end
            if (par_en)
                parity <= parity ^ bit_in;
        end
    end

endmodule

// File: rtl/c432_key_loader.sv
// rtl/c432_key_loader.sv - serial even-parity key loader driving the c432 lock-key inputs
module c432_key_loader
    import c432_lock_pkg::*;
#(
    parameter int MUX_W_P = MUX_W,
    parameter int XOR_W_P = XOR_W,
    parameter int CNT_W_P = CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic                       bit_i,
    input  logic                       bit_valid_i,
    output logic                       bit_ready_o,
    output logic [MUX_W_P+XOR_W_P-1:0] key_o,
    output logic                       key_valid_o,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam int KW = MUX_W_P + XOR_W_P;

    loader_state_t      state, state_nxt;
    logic               clr, shift_en, par_en, xfer;
    logic [KW-1:0]      sr;
    logic [CNT_W_P-1:0] cnt;
    logic               parity;

    key_shift_par #(
        .SR_W (KW),
        .CW   (CNT_W_P)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .shift_en (shift_en),
        .par_en   (par_en),
        .bit_in   (bit_i),
        .sr       (sr),
        .cnt      (cnt),
        .parity   (parity)
    );

    assign bit_ready_o = (state == LOAD) || (state == PAR);
    assign xfer        = bit_valid_i && bit_ready_o;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // start_i wins over everything: a bit offered alongside it is dropped
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        if (start_i) begin
            state_nxt = LOAD;
            clr       = 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    if (xfer) begin
                        shift_en = 1'b1;
                        par_en   = 1'b1;
                        if (cnt == CNT_W_P'(KW - 1))
                            state_nxt = PAR;
                    end
                end
                PAR: begin
                    if (xfer) begin
                        par_en    = 1'b1;
                        state_nxt = CHECK;
                    end
                end
                CHECK:   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Parity register holds XOR of key and parity bit in CHECK; zero means even parity held
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_o       <= '0;
            key_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
        end else if (start_i) begin
            key_o       <= '0;
            key_valid_o <= 1'b0;
            busy_o      <= 1'b1;
            err_o       <= 1'b0;
        end else if (state == CHECK) begin
            busy_o <= 1'b0;
            if (!parity) begin
                key_o       <= sr;
                key_valid_o <= 1'b1;
            end else begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_c432_key_loader.sv
// tb/tb_c432_key_loader.sv - directed self-checking bench for c432_key_loader
module tb_c432_key_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        bit_i;
    logic        bit_valid_i;
    logic        bit_ready_o;
    logic [25:0] key_o;
    logic        key_valid_o;
    logic        busy_o;
    logic        err_o;

    int n_cmp = 0;
    int n_err = 0;

    c432_key_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .bit_i       (bit_i),
        .bit_valid_i (bit_valid_i),
        .bit_ready_o (bit_ready_o),
        .key_o       (key_o),
        .key_valid_o (key_valid_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Sends nb key bits LSB-first, optionally with an idle cycle after each
    task automatic send_bits(input logic [25:0] key, input int nb, input bit gaps);
        for (int i = 0; i < nb; i++) begin
            bit_valid_i = 1'b1;
            bit_i       = key[i];
            tick();
            if (gaps) begin
                bit_valid_i = 1'b0;
                bit_i       = ~key[i];
                tick();
            end
        end
        bit_valid_i = 1'b0;
    endtask

    task automatic send_par(input logic p);
        bit_valid_i = 1'b1;
        bit_i       = p;
        tick();
        bit_valid_i = 1'b0;
        bit_i       = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        start_i     = 1'b0;
        bit_i       = 1'b0;
        bit_valid_i = 1'b0;
        tick();
        tick();
        check("rst_key",   32'(key_o),       32'h0);
        check("rst_valid", 32'(key_valid_o), 32'h0);
        check("rst_busy",  32'(busy_o),      32'h0);
        check("rst_ready", 32'(bit_ready_o), 32'h0);
        check("rst_err",   32'(err_o),       32'h0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a load
        do_start();
        check("start_busy",  32'(busy_o),      32'h1);
        check("start_ready", 32'(bit_ready_o), 32'h1);
        send_bits(26'h3FF_FFFF, 10, 1'b0);
        rst_n       = 1'b0;
        bit_valid_i = 1'b1;
        bit_i       = 1'b1;
        tick();
        bit_valid_i = 1'b0;
        rst_n       = 1'b1;
        check("midrst_key",   32'(key_o),       32'h0);
        check("midrst_valid", 32'(key_valid_o), 32'h0);
        check("midrst_busy",  32'(busy_o),      32'h0);
        check("midrst_ready", 32'(bit_ready_o), 32'h0);

        // Gapless load of 26'h2A5_5A5A: popcount 13, even-parity bit is 1
        do_start();
        send_bits(26'h2A5_5A5A, 26, 1'b0);
        check("par_ready", 32'(bit_ready_o), 32'h1);
        check("par_key0",  32'(key_o),       32'h0);
        send_par(1'b1);
        check("chk_ready", 32'(bit_ready_o), 32'h0);
        check("chk_valid", 32'(key_valid_o), 32'h0);
        check("chk_busy",  32'(busy_o),      32'h1);
        tick();
        check("good_key",   32'(key_o),       32'h2A5_5A5A);
        check("good_valid", 32'(key_valid_o), 32'h1);
        check("good_err",   32'(err_o),       32'h0);
        check("good_busy",  32'(busy_o),      32'h0);

        // Same key with inverted parity bit
        do_start();
        check("wd_key",   32'(key_o),       32'h0);
        check("wd_valid", 32'(key_valid_o), 32'h0);
        send_bits(26'h2A5_5A5A, 26, 1'b0);
        send_par(1'b0);
        tick();
        check("bad_key",   32'(key_o),       32'h0);
        check("bad_valid", 32'(key_valid_o), 32'h0);
        check("bad_err",   32'(err_o),       32'h1);
        check("bad_busy",  32'(busy_o),      32'h0);

        // Gapped load: bit_valid_i toggles, gap cycles carry the inverted bit
        do_start();
        check("gap_err_clr", 32'(err_o), 32'h0);
        send_bits(26'h2A5_5A5A, 26, 1'b1);
        send_par(1'b1);
        tick();
        check("gap_key",   32'(key_o),       32'h2A5_5A5A);
        check("gap_valid", 32'(key_valid_o), 32'h1);
        check("gap_err",   32'(err_o),       32'h0);

        // All-ones key (26 ones -> parity 0), withdraw, then reload 1 (parity 1)
        do_start();
        send_bits(26'h3FF_FFFF, 26, 1'b0);
        send_par(1'b0);
        tick();
        check("ones_key",   32'(key_o),       32'h3FF_FFFF);
        check("ones_valid", 32'(key_valid_o), 32'h1);
        do_start();
        check("withdraw_key",   32'(key_o),       32'h0);
        check("withdraw_valid", 32'(key_valid_o), 32'h0);
        check("withdraw_busy",  32'(busy_o),      32'h1);
        send_bits(26'h000_0001, 26, 1'b0);
        send_par(1'b1);
        tick();
        check("one_key",   32'(key_o),       32'h000_0001);
        check("one_valid", 32'(key_valid_o), 32'h1);

        // bit_valid_i in IDLE is ignored
        bit_valid_i = 1'b1;
        bit_i       = 1'b0;
        tick();
        check("idle_ready", 32'(bit_ready_o), 32'h0);
        tick();
        bit_valid_i = 1'b0;
        check("idle_key", 32'(key_o), 32'h000_0001);

        // start_i with the 13th bit: that bit dropped, fresh 26'h155_5555 (parity 1)
        do_start();
        send_bits(26'h3FF_FFFF, 12, 1'b0);
        bit_valid_i = 1'b1;
        bit_i       = 1'b1;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
        bit_valid_i = 1'b0;
        check("abort_busy", 32'(busy_o), 32'h1);
        check("abort_key",  32'(key_o),  32'h0);
        send_bits(26'h155_5555, 26, 1'b0);
        check("abort_par_ready", 32'(bit_ready_o), 32'h1);
        send_par(1'b1);
        tick();
        check("abort_commit", 32'(key_o),       32'h155_5555);
        check("abort_valid",  32'(key_valid_o), 32'h1);
        check("abort_err",    32'(err_o),       32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
